ondra_parallel_sink: RTL
========================

// Module: ondra_parallel_sink
// PURPOSE
// - Peripheral (printer) end of the Ondra parallel port: receives Parallel_Data_OUT/NON_STB from the core, returns BUSY.
// - Captures each strobed byte into a FIFO and presents it on a valid/ready stream to the host side (HPS file/print capture).
// - Implements the BUSY flow control that ROM print routines poll on the keyboard-port read.
// PARAMETERS
// - FIFO_AW        4   log2 FIFO depth (16 entries)
// - SYNC_STAGES    2   synchronizer flops on par_data and strobe_n
// - STB_MIN_CYCLES 4   consecutive low samples of strobe_n needed to accept a strobe (glitch filter)
// - BUSY_MIN       16  minimum clk_sys cycles BUSY stays high per accepted byte
// PORTS
// - clk_sys       in   1          system clock (8 MHz)
// - reset         in   1          async, active-high
// - par_data      in   8          byte from port A1 latch
// - strobe_n      in   1          NON_STB, active-low strobe
// - busy          out  1          BUSY to core keyboard port bit 5
// - m_data        out  8          head-of-FIFO byte
// - m_valid       out  1          m_data valid
// - m_ready       in   1          host accepts m_data
// - overflow      out  1          sticky: byte dropped (strobe while FIFO full)
// - overflow_clr  in   1          synchronous clear of overflow
// - fifo_level    out  FIFO_AW+1  entries currently stored
// BEHAVIOUR
// - Reset reset async active-high, clock clk_sys. Reset values: busy=1, m_valid=0, m_data=0, overflow=0, fifo_level=0, FSM=DISARMED.
// - par_data and strobe_n pass through SYNC_STAGES flops; all logic uses synced copies only.
// - Filter: counter increments while synced strobe_n=0, saturates at STB_MIN_CYCLES, clears on any 1 sample.
// - Strobe event: single cycle in which filter counter reaches STB_MIN_CYCLES. Event byte = synced par_data of that cycle.
// - FSM:
//   DISARMED: busy=1; leaves to IDLE after synced strobe_n=1 for one cycle (core resets NON_STB to 0; never accept that level).
//   IDLE: busy=1 if FIFO full, else busy=0; on strobe event -> HOLD, push byte (or drop if full), load hold counter with BUSY_MIN-1.
//   HOLD: busy=1; counter decrements to 0 -> RELEASE.
//   RELEASE: busy=1 until synced strobe_n=1; then -> IDLE (busy then follows FIFO full).
// - Latency: strobe_n pin falling -> busy=1 after exactly SYNC_STAGES+STB_MIN_CYCLES+1 clk_sys edges (default 7).
// - Push at edge ending event cycle; if FIFO was empty m_valid=1 on the next cycle (byte-to-stream 1 cycle).
// - Stream: show-ahead; pop when m_valid & m_ready; m_data/m_valid stable while m_valid & ~m_ready.
// - Full + strobe event: if pop in same cycle, push accepted (level unchanged); else byte dropped, overflow<=1.
// - Empty + push + pop same cycle: impossible (m_valid=0); push only.
// - overflow_clr and new overflow same cycle: overflow stays 1 (set wins).
// - fifo_level = write count - read count, FIFO_AW+1 bits; pointers wrap modulo 2^FIFO_AW.
// - Strobe event outside IDLE (strobe re-asserted in HOLD/RELEASE without release): ignored, no push.
// - Reset mid-operation: FIFO emptied, FSM to DISARMED, overflow cleared; no partial byte survives.
// STRUCTURE
// - Package ondra_par_pkg: state enum {DISARMED, IDLE, HOLD, RELEASE}, default parameter constants.
// - Sub-module ondra_byte_fifo: sync show-ahead FIFO (push, pop, din, dout, empty, full, level), async reset.
// - Top holds synchronizers, filter counter, FSM, hold counter, overflow flag.
// TESTING
// - Reset with strobe_n=0, par_data=8'h41: busy=1, no push; raise strobe_n -> busy=0 after SYNC_STAGES+1 cycles.
// - par_data=8'h55, strobe_n low 10 cycles, m_ready=1: busy=1 at edge 7, m_data=8'h55 m_valid one cycle, busy low >=16 cycles later only after strobe_n high.
// - strobe_n low pulse of 3 cycles (< STB_MIN_CYCLES): no push, busy stays 0, fifo_level=0.
// - m_ready=0, send 16 bytes 8'h00..8'h0F: fifo_level=16, busy=1 in IDLE; 17th strobe (8'hAA) dropped, overflow=1; drain returns 00..0F in order.
// - FIFO full, strobe event coincident with m_ready=1 pop: byte accepted, level stays 16, overflow=0.
// - Assert reset during HOLD with 3 bytes queued: m_valid=0, fifo_level=0, busy=1, overflow=0 next cycle.

Source files
------------

// File: rtl/ondra_par_pkg.sv
// Shared types and default constants for the Ondra parallel-port
// printer sink.
package ondra_par_pkg;

  localparam int FIFO_AW_DEF     = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int STB_MIN_DEF     = 4;
  localparam int BUSY_MIN_DEF    = 16;

  typedef enum logic [1:0] {
    DISARMED,
    IDLE,
    HOLD,
    RELEASE
  } par_state_e;

endpackage

// File: rtl/ondra_byte_fifo.sv
// Byte FIFO with show-ahead output.
// The level is derived from free-running write/read counts.
module ondra_byte_fifo #(
  parameter int AW = 4
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW:0] wr_q, rd_q;
  logic [7:0]  mem_q [2**AW];
  logic        push_ok, pop_ok;

  assign level   = wr_q - rd_q;
  assign empty   = (level == '0);
  assign full    = (level == DEPTH);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  // An empty FIFO presents zero so no stale byte leaks after reset.
  assign dout    = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(push_ok);
      rd_q <= rd_q + (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/ondra_parallel_sink.sv
// Printer end of the Ondra parallel port: strobe filter, BUSY
// handshake FSM and byte FIFO onto a valid/ready stream.
module ondra_parallel_sink
  import ondra_par_pkg::*;
#(
  parameter int FIFO_AW        = FIFO_AW_DEF,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int STB_MIN_CYCLES = STB_MIN_DEF,
  parameter int BUSY_MIN       = BUSY_MIN_DEF
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [7:0]         par_data,
  input  logic               strobe_n,
  output logic               busy,
  output logic [7:0]         m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               overflow,
  input  logic               overflow_clr,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int FW = $clog2(STB_MIN_CYCLES + 1);
  localparam int HW = $clog2(BUSY_MIN + 1);
  localparam logic [FW-1:0] FLT_MAX = FW'(STB_MIN_CYCLES);
  localparam logic [HW-1:0] HOLD_LD = HW'(BUSY_MIN - 1);

  logic [SYNC_STAGES-1:0]      stb_sync_q;
  logic [SYNC_STAGES-1:0][7:0] dat_sync_q;
  logic                        stb_s;
  logic [7:0]                  dat_s;

  logic [FW-1:0] flt_q, flt_d;
  logic          hit_q, hit_d;
  logic [HW-1:0] hold_q, hold_d;
  par_state_e    state_q, state_d;
  logic          ovf_q, ovf_set;
  logic          push, pop, empty, full;

  assign stb_s = stb_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      stb_sync_q <= '0;
      dat_sync_q <= '0;
    end else begin
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], strobe_n};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], par_data};
    end
  end

  // hit_q marks the single cycle after the filter first saturates.
  always_comb begin
    flt_d = flt_q;
    hit_d = 1'b0;
    if (stb_s) begin
      flt_d = '0;
    end else if (flt_q != FLT_MAX) begin
      flt_d = flt_q + 1'b1;
      hit_d = (flt_q == FLT_MAX - 1'b1);
    end
  end

  assign pop = m_valid && m_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    busy    = 1'b1;
    push    = 1'b0;
    ovf_set = 1'b0;
    unique case (state_q)
      DISARMED: begin
        if (stb_s) state_d = IDLE;
      end
      IDLE: begin
        busy = full;
        if (hit_q) begin
          state_d = HOLD;
          hold_d  = HOLD_LD;
          if (!full || pop) push    = 1'b1;
          else              ovf_set = 1'b1;
        end
      end
      HOLD: begin
        if (hold_q == '0) state_d = RELEASE;
        else              hold_d  = hold_q - 1'b1;
      end
      RELEASE: begin
        if (stb_s) state_d = IDLE;
      end
      default: state_d = DISARMED;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      flt_q   <= '0;
      hit_q   <= 1'b0;
      hold_q  <= '0;
      state_q <= DISARMED;
      ovf_q   <= 1'b0;
    end else begin
      flt_q   <= flt_d;
      hit_q   <= hit_d;
      hold_q  <= hold_d;
      state_q <= state_d;
      if (ovf_set)           ovf_q <= 1'b1;
      else if (overflow_clr) ovf_q <= 1'b0;
    end
  end

  assign overflow = ovf_q;
  assign m_valid  = !empty;

  ondra_byte_fifo #(
    .AW(FIFO_AW)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .din     (dat_s),
    .dout    (m_data),
    .empty   (empty),
    .full    (full),
    .level   (fifo_level)
  );

endmodule
